copy_token_splitter: RTL and testbench
======================================

Name: copy_token_splitter

Overview:
- Consumer stage directly downstream of the parser-to-copy token FIFO in the Snappy decompressor.
- Pops one 33-bit copy token (offset, length, end-of-block) per operation.
- Splits each token into a sequence of history-buffer copy commands:
  - no command longer than MAX_CHUNK bytes;
  - no command longer than the copy offset, so overlapping copies (offset < length) never read bytes the command itself has not yet written.
- Drives the valid/ready command interface of the copy engine.

Parameters:
- TOKEN_W, 33, FIFO word width; bit 32 = eob, bits 31:16 = offset, bits 15:0 = length.
- OFF_W, 16, offset field width.
- LEN_W, 16, length field width.
- MAX_CHUNK, 16, maximum bytes per emitted command; power of two, at least 1.
- CHUNK_W, 5, width of cmd_len; must hold MAX_CHUNK.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  token FIFO empty.
- fifo_dout  in  TOKEN_W  token FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  token FIFO pop.
- cmd_valid  out  1  copy command valid.
- cmd_ready  in  1  copy engine accepts the command.
- cmd_offset  out  OFF_W  back-reference distance in bytes.
- cmd_pos  out  LEN_W  byte index of this chunk within the token, starting at 0.
- cmd_len  out  CHUNK_W  chunk byte count, range 1..MAX_CHUNK.
- cmd_last  out  1  final chunk of the token.
- cmd_eob  out  1  final chunk of an end-of-block token.
- busy  out  1  token held or in flight.
- err  out  1  sticky malformed-token flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE;
  - every output and internal register goes to 0, including err.
  - Reset asserted mid-token abandons the token; the popped token is lost, with no recovery.
- FIFO read contract:
  - The FIFO has registered output.
  - fifo_dout is sampled exactly one cycle after the cycle in which fifo_rd_en was high.
  - fifo_rd_en is asserted only when fifo_empty is low.
  - fifo_rd_en is high for at most one cycle per token.
- State IDLE:
  - fifo_rd_en = !fifo_empty, combinational.
  - If the FIFO is not empty, go to LOAD.
- State LOAD:
  - Capture off_r, rem_r (length), eob_r.
  - Clear pos_r.
  - If offset == 0 or length == 0: set err, drop the token, go to IDLE.
  - Otherwise go to ISSUE.
- State ISSUE:
  - chunk = min(rem_r, MAX_CHUNK, off_r), computed in LEN_W-bit unsigned arithmetic.
  - cmd_valid = 1.
  - cmd_offset = off_r, cmd_pos = pos_r, cmd_len = chunk.
  - cmd_last = (rem_r == chunk).
  - cmd_eob = eob_r & cmd_last.
  - On cmd_valid & cmd_ready: pos_r += chunk, rem_r -= chunk.
    - If cmd_last, go to IDLE.
    - Otherwise stay in ISSUE.
  - Without cmd_ready, all cmd_* outputs hold stable.
  - cmd_valid never drops before the handshake.
- Throughput:
  - A token of N chunks occupies N + 2 cycles with cmd_ready held high.
  - The IDLE pop and the LOAD cycle are not overlapped with ISSUE.
- busy = (state != IDLE).
- err:
  - sticky until reset;
  - does not stall the block; subsequent tokens are processed normally.
- pos_r never wraps, because pos_r + rem_r <= length at all times.
- cmd_len never exceeds MAX_CHUNK, so CHUNK_W must cover it.

Decomposition:
- Shared package (snappy_pkg) holds:
  - TOKEN_W and the token field positions (EOB_BIT, OFF_MSB/LSB, LEN_MSB/LSB);
  - MAX_CHUNK;
  - the state enum {IDLE, LOAD, ISSUE}.
- One natural sub-module: chunk_min3.
  - Combinational three-way unsigned minimum of rem_r, MAX_CHUNK and off_r.
  - Reused by the literal path.
- FSM and counters stay in the top.

Test Plan:
1. Token off=100, len=40, eob=0; cmd_ready=1. Required: fifo_rd_en for one cycle, then 3 commands: (pos 0, len 16), (pos 16, len 16), (pos 32, len 8, last=1, eob=0). Total 5 cycles.
2. Overlap: off=3, len=10, eob=1. Required: commands of len 3, 3, 3, 1 at pos 0, 3, 6, 9. Only the final command has last=1 and eob=1.
3. Backpressure: off=64, len=16, cmd_ready low for 4 cycles then high. Required: cmd_valid=1 and all fields held constant for 4 cycles, then one command (len 16, last=1). fifo_rd_en not re-asserted while the FIFO is still empty.
4. Malformed: token off=0, len=5, followed by token off=8, len=8. Required: err=1 after LOAD with no command for the first token. The second token emits (pos 0, len 8, last=1), and err stays 1.
5. Reset mid-token: assert rst_n low during the 2nd chunk of off=100, len=48. Required: cmd_valid, busy and err go to 0 immediately (asynchronous). After release the block is IDLE and the next queued token starts at pos 0.
6. Back-to-back tokens, FIFO never empty, cmd_ready=1, each off=32, len=16. Required: one command per token every 3 cycles. fifo_rd_en is never asserted while fifo_empty=1.

Source files
------------

// File: rtl/snappy_pkg.sv
// snappy_pkg: constants shared by the Snappy decompressor copy path.
//   - copy token layout (33 bits: eob, 16-bit offset, 16-bit length)
//   - maximum bytes per history-buffer copy command
//   - FSM state encoding for the copy token splitter
package snappy_pkg;

   localparam int TOKEN_W   = 33;
   localparam int OFF_W     = 16;
   localparam int LEN_W     = 16;
   localparam int EOB_BIT   = 32;
   localparam int OFF_MSB   = 31;
   localparam int OFF_LSB   = 16;
   localparam int LEN_MSB   = 15;
   localparam int LEN_LSB   = 0;
   localparam int MAX_CHUNK = 16;
   localparam int CHUNK_W   = 5;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t LOAD  = 2'd1;
   localparam state_t ISSUE = 2'd2;

   // A zero offset or zero length cannot describe a back-reference.
   function automatic logic token_malformed(input logic [OFF_W-1:0] off,
                                            input logic [LEN_W-1:0] len);
      return (off == {OFF_W{1'b0}}) || (len == {LEN_W{1'b0}});
   endfunction

endpackage

// File: rtl/copy_token_splitter_if.sv
// copy_token_splitter_if: valid/ready copy command bus into the copy engine.
//   cmd_valid/cmd_ready        handshake
//   cmd_offset                 back-reference distance in bytes
//   cmd_pos                    byte index of the chunk inside its token
//   cmd_len                    chunk byte count (1..MAX_CHUNK)
//   cmd_last / cmd_eob         final chunk of token / of end-of-block token
// master = command producer (splitter), slave = copy engine.
interface copy_token_splitter_if;
   import snappy_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [OFF_W-1:0]   cmd_offset;
   logic [LEN_W-1:0]   cmd_pos;
   logic [CHUNK_W-1:0] cmd_len;
   logic               cmd_last;
   logic               cmd_eob;

   modport master (
      output cmd_valid, cmd_offset, cmd_pos, cmd_len, cmd_last, cmd_eob,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_offset, cmd_pos, cmd_len, cmd_last, cmd_eob,
      output cmd_ready
   );

endinterface

// File: rtl/chunk_min3.sv
// chunk_min3: combinational three-way unsigned minimum.
//   a, b, c : W-bit unsigned operands
//   y       : min(a, b, c)
// Used to size a copy chunk as min(remaining, MAX_CHUNK, offset).
module chunk_min3 #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] y
);

   logic [W-1:0] ab_s;

   // Pairwise minimum, then against the third operand.
   always_comb begin
      ab_s = a;
      y    = a;
      if (b < a) begin
         ab_s = b;
      end else begin
         ab_s = a;
      end
      if (c < ab_s) begin
         y = c;
      end else begin
         y = ab_s;
      end
   end

endmodule

// File: rtl/copy_token_splitter.sv
// copy_token_splitter: pops copy tokens from the parser FIFO and splits each
// into history-buffer copy commands no longer than MAX_CHUNK and no longer
// than the copy offset, so overlapping copies only read already-written bytes.
//   clk, rst_n      clock, asynchronous active-low reset
//   fifo_empty      token FIFO empty
//   fifo_dout       token FIFO data, valid the cycle after fifo_rd_en
//   fifo_rd_en      token FIFO pop
//   cmd             copy command bus (master side)
//   busy            token held or in flight
//   err             sticky malformed-token flag
module copy_token_splitter
   import snappy_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [TOKEN_W-1:0]    fifo_dout,
   output logic                  fifo_rd_en,
   copy_token_splitter_if.master cmd,
   output logic                  busy,
   output logic                  err
);

   localparam logic [LEN_W-1:0] MAX_CHUNK_L = LEN_W'(MAX_CHUNK);

   state_t           state_r;
   logic [OFF_W-1:0] off_r;
   logic [LEN_W-1:0] rem_r;
   logic [LEN_W-1:0] pos_r;
   logic             eob_r;
   logic             err_r;
   logic [LEN_W-1:0] chunk_s;
   logic             last_s;

   chunk_min3 #(.W(LEN_W)) u_min3 (
      .a (rem_r),
      .b (MAX_CHUNK_L),
      .c (off_r),
      .y (chunk_s)
   );

   assign last_s = (rem_r == chunk_s);
   assign busy   = (state_r != IDLE);
   assign err    = err_r;

   // FIFO pop and command bus drive; pop is held off while reset is asserted
   // so no token is consumed that the FSM would not capture.
   always_comb begin
      fifo_rd_en     = 1'b0;
      cmd.cmd_valid  = 1'b0;
      cmd.cmd_offset = {OFF_W{1'b0}};
      cmd.cmd_pos    = {LEN_W{1'b0}};
      cmd.cmd_len    = {CHUNK_W{1'b0}};
      cmd.cmd_last   = 1'b0;
      cmd.cmd_eob    = 1'b0;
      if ((state_r == IDLE) && rst_n) begin
         fifo_rd_en = !fifo_empty;
      end else begin
         fifo_rd_en = 1'b0;
      end
      if (state_r == ISSUE) begin
         cmd.cmd_valid  = 1'b1;
         cmd.cmd_offset = off_r;
         cmd.cmd_pos    = pos_r;
         cmd.cmd_len    = chunk_s[CHUNK_W-1:0];
         cmd.cmd_last   = last_s;
         cmd.cmd_eob    = eob_r & last_s;
      end else begin
         cmd.cmd_valid  = 1'b0;
      end
   end

   // Token FSM: pop in IDLE, capture in LOAD, emit chunks in ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         off_r   <= {OFF_W{1'b0}};
         rem_r   <= {LEN_W{1'b0}};
         pos_r   <= {LEN_W{1'b0}};
         eob_r   <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!fifo_empty) begin
                  state_r <= LOAD;
               end else begin
                  state_r <= IDLE;
               end
            end
            LOAD: begin
               off_r <= fifo_dout[OFF_MSB:OFF_LSB];
               rem_r <= fifo_dout[LEN_MSB:LEN_LSB];
               eob_r <= fifo_dout[EOB_BIT];
               pos_r <= {LEN_W{1'b0}};
               if (token_malformed(fifo_dout[OFF_MSB:OFF_LSB],
                                   fifo_dout[LEN_MSB:LEN_LSB])) begin
                  err_r   <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  state_r <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd.cmd_ready) begin
                  pos_r <= pos_r + chunk_s;
                  rem_r <= rem_r - chunk_s;
                  if (last_s) begin
                     state_r <= IDLE;
                  end else begin
                     state_r <= ISSUE;
                  end
               end else begin
                  state_r <= ISSUE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_copy_token_splitter.sv
// tb_copy_token_splitter: directed self-checking bench for copy_token_splitter.
// A registered-output FIFO model feeds tokens; a monitor logs every command
// handshake with its cycle stamp; checks compare against hand-computed tables.
module tb_copy_token_splitter;
   import snappy_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty;
   logic [32:0] fifo_dout = 33'd0;
   logic        fifo_rd_en;
   logic        busy;
   logic        err;

   copy_token_splitter_if cif();

   copy_token_splitter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .cmd        (cif.master),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // FIFO model storage
   logic [32:0] mem [0:15];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   // Monitor state
   int cyc = 0, pop_cnt = 0, pop_cyc = 0, rd_viol = 0, hs_n = 0;
   logic [15:0] hs_pos [0:63];
   logic [15:0] hs_off [0:63];
   logic [4:0]  hs_len [0:63];
   logic        hs_last[0:63];
   logic        hs_eob [0:63];
   int          hs_cyc [0:63];

   int n_checks = 0;
   int n_fail   = 0;

   // FIFO pop with registered data, plus handshake logging.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         pop_cnt   <= pop_cnt + 1;
         pop_cyc   <= cyc;
         rd_ptr    <= rd_ptr + 1;
         fifo_dout <= mem[rd_ptr % 16];
         if (fifo_empty) rd_viol <= rd_viol + 1;
      end
      if (cif.cmd_valid && cif.cmd_ready) begin
         hs_pos[hs_n]  <= cif.cmd_pos;
         hs_off[hs_n]  <= cif.cmd_offset;
         hs_len[hs_n]  <= cif.cmd_len;
         hs_last[hs_n] <= cif.cmd_last;
         hs_eob[hs_n]  <= cif.cmd_eob;
         hs_cyc[hs_n]  <= cyc;
         hs_n          <= hs_n + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] off, input logic [15:0] len, input logic eob);
      mem[wr_ptr % 16] = {eob, off, len};
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_hs(input int target, input int budget);
      int k;
      k = 0;
      while (hs_n < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("handshake_timeout", 64'(hs_n >= target), 64'd1);
   endtask

   typedef struct {
      logic [15:0] off;
      logic [15:0] len;
      logic        eob;
      int          first;
      int          ncmd;
      int          cycles;
   } tok_vec_t;

   typedef struct {
      logic [15:0] pos;
      logic [4:0]  len;
      logic        last;
      logic        eob;
   } cmd_vec_t;

   tok_vec_t tv [0:3];
   cmd_vec_t cv [0:9];

   initial begin
      int base, pc, k;

      // Tokens: plain split, overlap split, exact MAX_CHUNK, offset 1.
      tv[0] = '{16'd100, 16'd40, 1'b0, 0, 3, 5};
      tv[1] = '{16'd3,   16'd10, 1'b1, 3, 4, 6};
      tv[2] = '{16'd20,  16'd16, 1'b1, 7, 1, 3};
      tv[3] = '{16'd1,   16'd2,  1'b0, 8, 2, 4};
      cv[0] = '{16'd0,  5'd16, 1'b0, 1'b0};
      cv[1] = '{16'd16, 5'd16, 1'b0, 1'b0};
      cv[2] = '{16'd32, 5'd8,  1'b1, 1'b0};
      cv[3] = '{16'd0,  5'd3,  1'b0, 1'b0};
      cv[4] = '{16'd3,  5'd3,  1'b0, 1'b0};
      cv[5] = '{16'd6,  5'd3,  1'b0, 1'b0};
      cv[6] = '{16'd9,  5'd1,  1'b1, 1'b1};
      cv[7] = '{16'd0,  5'd16, 1'b1, 1'b1};
      cv[8] = '{16'd0,  5'd1,  1'b0, 1'b0};
      cv[9] = '{16'd1,  5'd1,  1'b1, 1'b0};

      cif.cmd_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_cmd_valid", 64'(cif.cmd_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      check("reset_rd_en", 64'(fifo_rd_en), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven tokens with cmd_ready held high.
      cif.cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         base = hs_n;
         pc   = pop_cnt;
         push(tv[i].off, tv[i].len, tv[i].eob);
         wait_hs(base + tv[i].ncmd, 100);
         for (int j = 0; j < tv[i].ncmd; j++) begin
            check($sformatf("tok%0d_cmd%0d_pos", i, j), 64'(hs_pos[base+j]), 64'(cv[tv[i].first+j].pos));
            check($sformatf("tok%0d_cmd%0d_len", i, j), 64'(hs_len[base+j]), 64'(cv[tv[i].first+j].len));
            check($sformatf("tok%0d_cmd%0d_last", i, j), 64'(hs_last[base+j]), 64'(cv[tv[i].first+j].last));
            check($sformatf("tok%0d_cmd%0d_eob", i, j), 64'(hs_eob[base+j]), 64'(cv[tv[i].first+j].eob));
            check($sformatf("tok%0d_cmd%0d_off", i, j), 64'(hs_off[base+j]), 64'(tv[i].off));
         end
         check($sformatf("tok%0d_pops", i), 64'(pop_cnt - pc), 64'd1);
         check($sformatf("tok%0d_cycles", i), 64'(hs_cyc[base+tv[i].ncmd-1] - pop_cyc + 1), 64'(tv[i].cycles));
         @(negedge clk);
         check($sformatf("tok%0d_idle", i), 64'(busy), 64'd0);
      end

      // Backpressure: command must hold for 4 cycles without cmd_ready.
      cif.cmd_ready = 1'b0;
      base = hs_n;
      pc   = pop_cnt;
      push(16'd64, 16'd16, 1'b0);
      k = 0;
      while (!cif.cmd_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      for (int j = 0; j < 4; j++) begin
         if (j > 0) @(negedge clk);
         check("bp_valid", 64'(cif.cmd_valid), 64'd1);
         check("bp_fields", 64'({cif.cmd_offset, cif.cmd_pos, cif.cmd_len, cif.cmd_last, cif.cmd_eob}),
               64'({16'd64, 16'd0, 5'd16, 1'b1, 1'b0}));
         check("bp_no_hs", 64'(hs_n), 64'(base));
      end
      cif.cmd_ready = 1'b1;
      wait_hs(base + 1, 20);
      check("bp_len", 64'(hs_len[base]), 64'd16);
      check("bp_last", 64'(hs_last[base]), 64'd1);
      repeat (3) @(negedge clk);
      check("bp_pops", 64'(pop_cnt - pc), 64'd1);

      // Malformed token followed by a good one.
      base = hs_n;
      pc   = pop_cnt;
      push(16'd0, 16'd5, 1'b0);
      push(16'd8, 16'd8, 1'b0);
      k = 0;
      while (!err && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("bad_err_set", 64'(err), 64'd1);
      check("bad_no_cmd", 64'(hs_n), 64'(base));
      wait_hs(base + 1, 20);
      check("bad_next_pos", 64'(hs_pos[base]), 64'd0);
      check("bad_next_len", 64'(hs_len[base]), 64'd8);
      check("bad_next_last", 64'(hs_last[base]), 64'd1);
      check("bad_next_off", 64'(hs_off[base]), 64'd8);
      check("bad_err_sticky", 64'(err), 64'd1);
      @(negedge clk);
      check("bad_pops", 64'(pop_cnt - pc), 64'd2);

      // Reset in the middle of a token; the queued token starts clean.
      base = hs_n;
      push(16'd100, 16'd48, 1'b0);
      push(16'd5, 16'd5, 1'b1);
      wait_hs(base + 1, 20);
      check("rst_mid_pos", 64'(cif.cmd_pos), 64'd16);
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", 64'(cif.cmd_valid), 64'd0);
      check("rst_async_busy", 64'(busy), 64'd0);
      check("rst_async_err", 64'(err), 64'd0);
      repeat (2) @(negedge clk);
      check("rst_no_pop", 64'(fifo_rd_en), 64'd0);
      rst_n = 1'b1;
      wait_hs(base + 2, 20);
      check("rst_next_pos", 64'(hs_pos[base+1]), 64'd0);
      check("rst_next_len", 64'(hs_len[base+1]), 64'd5);
      check("rst_next_off", 64'(hs_off[base+1]), 64'd5);
      check("rst_next_last_eob", 64'({hs_last[base+1], hs_eob[base+1]}), 64'd3);
      @(negedge clk);

      // Back-to-back tokens: one command every 3 cycles.
      base = hs_n;
      pc   = pop_cnt;
      for (int j = 0; j < 4; j++) push(16'd32, 16'd16, 1'b0);
      wait_hs(base + 4, 60);
      for (int j = 0; j < 4; j++) begin
         check($sformatf("b2b%0d_cmd", j), 64'({hs_pos[base+j], hs_len[base+j], hs_last[base+j]}),
               64'({16'd0, 5'd16, 1'b1}));
         if (j > 0) check($sformatf("b2b%0d_gap", j), 64'(hs_cyc[base+j] - hs_cyc[base+j-1]), 64'd3);
      end
      repeat (3) @(negedge clk);
      check("b2b_pops", 64'(pop_cnt - pc), 64'd4);
      check("rd_en_while_empty", 64'(rd_viol), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
